// File: rtl/bar_signal_sync.sv
`default_nettype none
// bar_signal_sync: synchronises and debounces three bar inputs, then issues one-shot redraw requests.
// Optional draw_done watchdog is compiled in with macro BAR_SIGNAL_SYNC_TIMEOUT_EN.
module bar_signal_sync #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] raw_sig,
  input  logic       force_redraw,
  input  logic       draw_done,
  output logic [2:0] bar_sig,
  output logic       draw_req,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [19:0] DEB_LIMIT = 20'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  logic [2:0] raw_meta;
  logic [2:0] raw_sync;
  logic       force_meta;
  logic       force_sync;
  logic       force_prev;
  logic       force_rise;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw_meta   <= 3'b000;
      raw_sync   <= 3'b000;
      force_meta <= 1'b0;
      force_sync <= 1'b0;
      force_prev <= 1'b0;
    end else begin
      raw_meta   <= raw_sig;
      raw_sync   <= raw_meta;
      force_meta <= force_redraw;
      force_sync <= force_meta;
      force_prev <= force_sync;
    end
  end

  assign force_rise = force_sync & ~force_prev;

  logic [2:0] stable;
  logic [2:0] stable_upd;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_ch
      logic [19:0] cnt;
      logic [19:0] cnt_next;
      logic        st;

      assign cnt_next      = cnt + 20'd1;
      assign stable_upd[i] = (raw_sync[i] != st) && (cnt_next == DEB_LIMIT);
      assign stable[i]     = st;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt <= 20'd0;
          st  <= 1'b0;
        end else if (raw_sync[i] == st) begin
          cnt <= 20'd0;
        end else if (stable_upd[i]) begin
          st  <= raw_sync[i];
          cnt <= 20'd0;
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  endgenerate

  // Registered so that pending sets one edge after the stable bit moves.
  logic stable_evt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stable_evt <= 1'b0;
    else         stable_evt <= |stable_upd;
  end

  state_t state;
  logic   pending;
  logic   redraw_evt;

  assign redraw_evt = stable_evt | force_rise;

`ifdef BAR_SIGNAL_SYNC_TIMEOUT_EN
  localparam logic [19:0] TO_LIMIT = 20'(TIMEOUT_CYCLES);
  logic [19:0] wait_cnt;
  logic        timeout_hit;
  assign timeout_hit = (wait_cnt + 20'd1) == TO_LIMIT;
`else
  // Watchdog compiled out; the parameter stays referenced so both builds share one interface.
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pending  <= 1'b1;
      bar_sig  <= 3'b000;
      draw_req <= 1'b0;
      busy     <= 1'b0;
`ifdef BAR_SIGNAL_SYNC_TIMEOUT_EN
      wait_cnt    <= 20'd0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // A new event wins over the grant clear so no request is ever lost.
      if (redraw_evt)
        pending <= 1'b1;
      else if (state == IDLE && pending)
        pending <= 1'b0;

      unique case (state)
        IDLE: begin
          draw_req <= 1'b0;
          busy     <= 1'b0;
          if (pending) begin
            state    <= REQ;
            bar_sig  <= stable;
            draw_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        REQ: begin
          state    <= WAIT;
          draw_req <= 1'b0;
          busy     <= 1'b1;
`ifdef BAR_SIGNAL_SYNC_TIMEOUT_EN
          wait_cnt <= 20'd0;
`endif
        end
        WAIT: begin
          draw_req <= 1'b0;
          if (draw_done) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef BAR_SIGNAL_SYNC_TIMEOUT_EN
          end else if (timeout_hit) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 20'd1;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          draw_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
